// File: rtl/lsu.sv
// Load/store unit: takes one memory op from execute, runs a request/grant/response
// handshake with data memory, and returns sign/zero-extended load data for write-back.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module lsu (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  lsu_ready,
  input  logic [3:0]            ls_op,
  input  logic [`CPU_WIDTH-1:0] alu_res,
  input  logic [`CPU_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_idx,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [`CPU_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [`CPU_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [`CPU_WIDTH-1:0] dmem_rdata,
  output logic                  lsu_done,
  output logic                  wb_we,
  output logic [4:0]            wb_rd_idx,
  output logic [`CPU_WIDTH-1:0] wb_data,
  output logic                  misalign,
  output logic [`CPU_WIDTH-1:0] bad_addr
);

  localparam int unsigned XLEN  = `CPU_WIDTH;
  localparam int unsigned RIDXW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic             store;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  sdata;
    logic [RIDXW-1:0] rd;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [RIDXW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  bad_addr_q, bad_addr_d;

  logic             accept;
  logic             in_illegal;
  logic             in_misal;
  logic             in_fault;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_ext;
  logic [3:0]       lane_be;
  logic [XLEN-1:0]  lane_wdata;

  assign accept = ex_valid && (state_q == S_IDLE);

  // Fault classification of the incoming op, decided once at accept time
  always_comb begin
    in_illegal = 1'b0;
    in_misal   = 1'b0;
    if (ls_op[3]) begin
      in_illegal = (ls_op[2:0] > 3'b010);
    end else begin
      in_illegal = (ls_op[2:0] == 3'b011) || (ls_op[2:0] == 3'b110) ||
                   (ls_op[2:0] == 3'b111);
    end
    case (ls_op[1:0])
      2'b01:   in_misal = alu_res[0];
      2'b10:   in_misal = (alu_res[1:0] != 2'b00);
      default: in_misal = 1'b0;
    endcase
    in_fault = in_illegal || in_misal;
  end

  // Byte lanes and replicated write data for the captured op
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = op_q.sdata;
    case (op_q.funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << op_q.addr[1:0];
        lane_wdata = {4{op_q.sdata[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << {op_q.addr[1], 1'b0};
        lane_wdata = {2{op_q.sdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = op_q.sdata;
      end
    endcase
  end

  // Load data lane select and extension
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (op_q.addr[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = op_q.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q.funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = in_fault ? S_RESP : S_REQ;
      S_REQ:  if (dmem_gnt) state_d = op_q.store ? S_RESP : S_WAIT;
      S_WAIT: if (dmem_rvalid) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state and captured-op registers only
  always_comb begin
    lsu_ready  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    lsu_done   = 1'b0;
    wb_we      = 1'b0;
    misalign   = 1'b0;
    dmem_addr  = {op_q.addr[XLEN-1:2], 2'b00};
    dmem_wdata = lane_wdata;
    case (state_q)
      S_IDLE: lsu_ready = 1'b1;
      S_REQ: begin
        dmem_req = 1'b1;
        dmem_we  = op_q.store;
        dmem_be  = lane_be;
      end
      S_RESP: begin
        lsu_done = 1'b1;
        wb_we    = !op_q.store && !fault_q;
        misalign = fault_q;
      end
      default: ;
    endcase
  end

  // Captured op and write-back datapath next values
  always_comb begin
    op_d       = op_q;
    fault_d    = fault_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    bad_addr_d = bad_addr_q;
    if (accept) begin
      op_d.store  = ls_op[3];
      op_d.funct3 = ls_op[2:0];
      op_d.addr   = alu_res;
      op_d.sdata  = store_data;
      op_d.rd     = rd_idx;
      fault_d     = in_fault;
      if (in_fault) bad_addr_d = alu_res;
    end
    if ((state_q == S_WAIT) && dmem_rvalid) begin
      wb_data_d = ld_ext;
      wb_rd_d   = op_q.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      fault_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      bad_addr_q <= '0;
    end else begin
      op_q       <= op_d;
      fault_q    <= fault_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign wb_data   = wb_data_q;
  assign wb_rd_idx = wb_rd_q;
  assign bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives ops against a scripted memory and checks
// write-back results through a scoreboard popped on each lsu_done.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        lsu_ready;
  logic [3:0]  ls_op;
  logic [31:0] alu_res;
  logic [31:0] store_data;
  logic [4:0]  rd_idx;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        lsu_done;
  logic        wb_we;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] bad_addr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        we;
    logic        mis;
    logic [31:0] data;
    logic [31:0] bad;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  logic [31:0] last_wb;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .lsu_ready(lsu_ready),
    .ls_op(ls_op), .alu_res(alu_res), .store_data(store_data), .rd_idx(rd_idx),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .lsu_done(lsu_done),
    .wb_we(wb_we), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
    .misalign(misalign), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic bit exp_fault(input bit st, input bit [2:0] f3, input logic [31:0] a);
    bit ill;
    bit mis;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    return ill || mis;
  endfunction

  function automatic logic [3:0] exp_be(input bit [2:0] f3, input logic [31:0] a);
    logic [3:0] one;
    one = 4'b0001;
    if (f3[1:0] == 2'd0) return one << a[1:0];
    if (f3[1:0] == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wd(input bit [2:0] f3, input logic [31:0] sd);
    if (f3[1:0] == 2'd0) return 32'(sd[7:0]) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return 32'(sd[15:0]) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] ld_model(input bit [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = rdat >> {a[1:0], 3'b000};
    hsh = rdat >> {a[1], 4'b0000};
    case (f3)
      3'd0:    return 32'($signed(bsh[7:0]));
      3'd1:    return 32'($signed(hsh[15:0]));
      3'd4:    return 32'(bsh[7:0]);
      3'd5:    return 32'(hsh[15:0]);
      default: return rdat;
    endcase
  endfunction

  // Scoreboard: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && lsu_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(lsu_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_wb_we", 32'(wb_we), 32'(e.we));
        chk("resp_misalign", 32'(misalign), 32'(e.mis));
        if (e.we) begin
          chk("resp_wb_data", wb_data, e.data);
          chk("resp_wb_rd", 32'(wb_rd_idx), 32'(e.rd));
        end
        if (e.mis) chk("resp_bad_addr", bad_addr, e.bad);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete op; entered and left at a negedge with the LSU idle
  task automatic do_op(input string tag, input bit st, input bit [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input int gw, input logic [31:0] rdat);
    exp_t e;
    bit   flt;
    flt    = exp_fault(st, f3, a);
    e.we   = !st && !flt;
    e.mis  = flt;
    e.data = ld_model(f3, a, rdat);
    e.bad  = a;
    e.rd   = rd;
    chk({tag, ":ready"}, 32'(lsu_ready), 32'd1);
    ex_valid = 1'b1; ls_op = {st, f3}; alu_res = a; store_data = sd; rd_idx = rd;
    sb.push_back(e);
    tick();
    ex_valid = 1'b0; ls_op = 4'($urandom); alu_res = $urandom; store_data = $urandom;
    if (flt) begin
      chk({tag, ":no_req"}, 32'(dmem_req), 32'd0);
    end else begin
      for (int i = 0; i <= gw; i++) begin
        chk({tag, ":req"}, 32'(dmem_req), 32'd1);
        chk({tag, ":we"}, 32'(dmem_we), 32'(st));
        chk({tag, ":addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, ":be"}, 32'(dmem_be), 32'(exp_be(f3, a)));
        if (st) chk({tag, ":wdata"}, dmem_wdata, exp_wd(f3, sd));
        chk({tag, ":busy"}, 32'(lsu_ready), 32'd0);
        dmem_gnt    = (i == gw);
        dmem_rvalid = (i < gw);
        dmem_rdata  = $urandom;
        tick();
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (!st) begin
        chk({tag, ":wait_req"}, 32'(dmem_req), 32'd0);
        chk({tag, ":wait_be"}, 32'(dmem_be), 32'd0);
        chk({tag, ":wait_done"}, 32'(lsu_done), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdat;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
      end
    end
    chk({tag, ":done"}, 32'(lsu_done), 32'd1);
    if (e.we) last_wb = e.data;
    tick();
    chk({tag, ":done_pulse"}, 32'(lsu_done), 32'd0);
    chk({tag, ":idle_wb_we"}, 32'(wb_we), 32'd0);
    chk({tag, ":idle_mis"}, 32'(misalign), 32'd0);
    chk({tag, ":idle_ready"}, 32'(lsu_ready), 32'd1);
    chk({tag, ":wb_hold"}, wb_data, last_wb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ls_op = '0; alu_res = '0; store_data = '0;
    rd_idx = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    last_wb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd_idx), 32'd0);
    chk("rst_bad_addr", bad_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("lw",   1'b0, 3'd2, 32'h100, 32'h0, 5'd1, 0, 32'hDEADBEEF);
    do_op("lb",   1'b0, 3'd0, 32'h103, 32'h0, 5'd2, 0, 32'h80123456);
    do_op("lbu",  1'b0, 3'd4, 32'h103, 32'h0, 5'd3, 1, 32'h80123456);
    do_op("lhu",  1'b0, 3'd5, 32'h102, 32'h0, 5'd4, 0, 32'h80123456);
    do_op("lh",   1'b0, 3'd1, 32'h102, 32'h0, 5'd5, 2, 32'h80123456);
    do_op("lb1",  1'b0, 3'd0, 32'h101, 32'h0, 5'd6, 0, 32'h0000_7F00);
    do_op("lw_x0", 1'b0, 3'd2, 32'h104, 32'h0, 5'd0, 0, 32'h1357_9BDF);
    do_op("sh",   1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd0, 3, 32'h0);
    do_op("sb",   1'b1, 3'd0, 32'h201, 32'h0000_00EF, 5'd0, 0, 32'h0);
    do_op("sw",   1'b1, 3'd2, 32'h204, 32'hCAFE_F00D, 5'd0, 1, 32'h0);
    do_op("lw_mis", 1'b0, 3'd2, 32'h301, 32'h0, 5'd7, 0, 32'h0);
    do_op("lh_mis", 1'b0, 3'd5, 32'h305, 32'h0, 5'd8, 0, 32'h0);
    do_op("sh_mis", 1'b1, 3'd1, 32'h203, 32'h0, 5'd0, 0, 32'h0);
    do_op("ld_ill", 1'b0, 3'd3, 32'h100, 32'h0, 5'd9, 0, 32'h0);
    do_op("st_ill", 1'b1, 3'd4, 32'h100, 32'h0, 5'd0, 0, 32'h0);

    for (int k = 0; k < 10; k++) begin
      bit          st;
      bit [2:0]    f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = st ? 3'd0 : 3'd4;
        default: f3 = st ? 3'd1 : 3'd5;
      endcase
      a = $urandom;
      if (f3[1:0] == 2'd1) a[0] = 1'b0;
      if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      do_op("rnd", st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 2), $urandom);
    end

    // Back-to-back ops with ex_valid held: second accepted only once idle again
    ex_valid = 1'b1; ls_op = 4'b1010; alu_res = 32'h400; store_data = 32'h1111_2222; rd_idx = 5'd0;
    sb.push_back('{we: 1'b0, mis: 1'b0, data: 32'h0, bad: 32'h0, rd: 5'd0});
    tick();
    ls_op = 4'b0010; alu_res = 32'h404; rd_idx = 5'd12;
    chk("b2b_a_req", 32'(dmem_req), 32'd1);
    chk("b2b_a_addr", dmem_addr, 32'h400);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("b2b_a_done", 32'(lsu_done), 32'd1);
    chk("b2b_a_busy", 32'(lsu_ready), 32'd0);
    sb.push_back('{we: 1'b1, mis: 1'b0, data: 32'h0BAD_F00D, bad: 32'h0, rd: 5'd12});
    tick();
    chk("b2b_idle_ready", 32'(lsu_ready), 32'd1);
    chk("b2b_idle_req", 32'(dmem_req), 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("b2b_b_req", 32'(dmem_req), 32'd1);
    chk("b2b_b_addr", dmem_addr, 32'h404);
    chk("b2b_b_we", 32'(dmem_we), 32'd0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("b2b_b_done", 32'(lsu_done), 32'd1);
    tick();

    // Reset while waiting for load data; the late rvalid must be dropped
    ex_valid = 1'b1; ls_op = 4'b0010; alu_res = 32'h500; rd_idx = 5'd20;
    tick();
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rstw_in_wait", 32'(dmem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstw_ready", 32'(lsu_ready), 32'd1);
    chk("rstw_wb_data", wb_data, 32'd0);
    chk("rstw_done", 32'(lsu_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("rstw_no_done", 32'(lsu_done), 32'd0);
    chk("rstw_no_we", 32'(wb_we), 32'd0);
    chk("rstw_ready2", 32'(lsu_ready), 32'd1);
    tick();
    chk("rstw_no_done2", 32'(lsu_done), 32'd0);
    last_wb = 32'h0;
    do_op("post_rst_lw", 1'b0, 3'd2, 32'h600, 32'h0, 5'd21, 0, 32'h2468_ACE0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
